ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side responder for the processor control unit's memory handshake.
- The control unit raises MFA with an address, direction, size and write data, then waits in its MOC state.
- This block performs the byte/halfword/word access on a byte-addressed big-endian RAM after a programmable wait, then raises MOC.
- It holds MOC until the control unit drops MFA, and then returns to idle.

Parameters:
- ADDR_WIDTH, 9, byte-address width; memory depth is 2^ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles between request capture and MOC assertion; valid range 0..15.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MFA  in  1  memory function activate; a request is pending while high.
- RW  in  1  1 = read, 0 = write.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- Address  in  ADDR_WIDTH  byte address.
- DataIn  in  32  write data, right-justified for byte and halfword writes.
- DataOut  out  32  read data, zero-extended and right-justified.
- MOC  out  1  memory operation complete.

Behaviour:
- Reset (asynchronous, Reset=1): state IDLE, MOC=0, DataOut=0, wait counter=0. RAM contents are not cleared.
- FSM states are IDLE, WAIT, RESPOND, RELEASE.
- IDLE: on an edge with MFA=1, latch RW, Size, Address and DataIn into request registers.
  - If LATENCY>0: load counter=LATENCY-1 and go to WAIT.
  - If LATENCY=0: go directly to RESPOND.
  - Inputs are ignored after capture; changes while busy have no effect.
- WAIT: if counter==0, go to RESPOND; otherwise decrement the counter.
- Entry into RESPOND: the access executes on this edge.
  - MOC=1 is registered on the same edge.
  - For a read, DataOut is updated on the same edge.
- Latency: with MFA sampled high at edge k, MOC is high after edge k+LATENCY+1.
- RESPOND: MOC stays 1 while MFA=1. On an edge with MFA=0, MOC goes to 0 and the FSM goes to RELEASE.
- RELEASE: one dead cycle with MOC=0, then IDLE.
  - A new request can be captured no earlier than the edge after the RELEASE edge.
  - This guarantees MOC is seen low between back-to-back requests.
- Alignment:
  - Word accesses force Address[1:0]=00.
  - Halfword accesses force Address[0]=0.
  - Byte accesses have no forcing.
  - No misalignment error is reported.
- Big-endian addressing, with A = the aligned address:
  - Word: mem[A]→bits 31:24, mem[A+1]→23:16, mem[A+2]→15:8, mem[A+3]→7:0.
  - Halfword: mem[A]→15:8, mem[A+1]→7:0; DataOut[31:16]=0.
  - Byte: mem[A]→7:0; DataOut[31:8]=0.
- Writes use the same byte mapping from DataIn. Only the bytes selected by Size are modified.
- DataOut holds its value until the next completed read; writes never change DataOut.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- Reset mid-operation (in WAIT): the request is aborted, no RAM write occurs, MOC=0.
- Reset in RESPOND: the write has already completed, and MOC clears immediately.
- MFA dropped during WAIT (protocol violation): the access still completes. MOC pulses high for exactly one cycle, then RELEASE.
- Simultaneous Reset and MFA: Reset wins; no capture.

Test Plan:
- LATENCY=2; word write at 0x010 with DataIn=0xDEADBEEF; MFA held until MOC=1, then dropped.
  - MOC rises 3 edges after capture.
  - Byte reads then return 0x10→0xDE, 0x11→0xAD, 0x12→0xBE, 0x13→0xEF.
- Halfword read at 0x012 → DataOut=0x0000BEEF. Byte read at 0x011 → 0x000000AD. Word read at 0x013 (forced to 0x010) → 0xDEADBEEF.
- Byte write 0x55 to 0x012, then word read at 0x010 → 0xDEAD55EF. Neighbouring bytes are unchanged.
- MFA held high for 5 cycles after MOC rises → MOC stays 1 for all 5. MOC falls on the first edge with MFA=0, followed by one RELEASE cycle before the next capture.
- Word write 0x12345678 to 0x020, Reset pulsed during WAIT → MOC never rises; a subsequent read of 0x020 returns its prior value.
- LATENCY=0 instance: read request → MOC=1 after the first edge following capture. Back-to-back requests show MOC low for at least 1 cycle between them.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the control unit's MFA/MOC handshake.
// Captures a request, waits LATENCY cycles, performs a big-endian byte, halfword
// or word access on a byte-addressed RAM, then holds MOC until MFA is dropped.
module ram_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MFA,
    input  logic                  RW,
    input  logic [1:0]            Size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter reload value; unused when LATENCY is zero.
    localparam logic [3:0] wait_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic                    req_rw;
    logic [1:0]              req_size;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [31:0]             req_data;

    logic [7:0]              mem [0:(1 << ADDR_WIDTH) - 1];

    logic [ADDR_WIDTH-1:0]   addr0;
    logic [ADDR_WIDTH-1:0]   addr1;
    logic [ADDR_WIDTH-1:0]   addr2;
    logic [ADDR_WIDTH-1:0]   addr3;
    logic [31:0]             rd_data;
    logic                    do_access;
    logic                    do_write;

    // The access fires on the first RESPOND cycle, before MOC has been raised.
    assign do_access = (state == RESPOND) && !MOC;
    assign do_write  = do_access && !req_rw;

    // Force alignment by size and derive the four big-endian byte addresses.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        addr0 = req_addr;
        case (req_size)
            2'b00:   addr0 = req_addr;
            2'b01:   addr0[0] = 1'b0;
            default: addr0[1:0] = 2'b00;
        endcase
        addr1 = addr0 + ADDR_WIDTH'(1);
        addr2 = addr0 + ADDR_WIDTH'(2);
        addr3 = addr0 + ADDR_WIDTH'(3);
    end

    // Assemble zero-extended, right-justified read data from the selected bytes.
    always_comb begin
        rd_data = 32'd0;
        case (req_size)
            2'b00:   rd_data = {24'd0, mem[addr0]};
            2'b01:   rd_data = {16'd0, mem[addr0], mem[addr1]};
            default: rd_data = {mem[addr0], mem[addr1], mem[addr2], mem[addr3]};
        endcase
    end

    // RAM write port: only the bytes selected by the captured size are modified.
    // NOTE: the RAM array has no reset; its contents survive Reset and it maps onto plain memory.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            case (req_size)
                2'b00: begin
                    mem[addr0] <= req_data[7:0];
                end
                2'b01: begin
                    mem[addr0] <= req_data[15:8];
                    mem[addr1] <= req_data[7:0];
                end
                default: begin
                    mem[addr0] <= req_data[31:24];
                    mem[addr1] <= req_data[23:16];
                    mem[addr2] <= req_data[15:8];
                    mem[addr3] <= req_data[7:0];
                end
            endcase
        end
    end

    // Handshake FSM with registered MOC and DataOut.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            MOC      <= 1'b0;
            DataOut  <= 32'd0;
            req_rw   <= 1'b0;
            req_size <= 2'b00;
            req_addr <= '0;
            req_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (MFA) begin
                        req_rw   <= RW;
                        req_size <= Size;
                        req_addr <= Address;
                        req_data <= DataIn;
                        if (LATENCY > 0) begin
                            wait_cnt <= wait_load;
                            state    <= WAIT;
                        end else begin
                            state    <= RESPOND;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    if (!MOC) begin
                        // Access edge: the write lands in the RAM block, reads update DataOut.
                        MOC <= 1'b1;
                        if (req_rw) begin
                            DataOut <= rd_data;
                        end
                    end else if (!MFA) begin
                        MOC   <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Dead cycle guarantees MOC is observed low between requests.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed scoreboard bench for ram_responder.
// Index 0 is a LATENCY=0 instance, index 1 a LATENCY=2 instance; both share
// clock and reset. Stimulus pushes the expected DataOut at each MOC rise into
// a per-instance queue; a negedge monitor pops and compares on every MOC rise.
module tb_ram_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;
    localparam logic       RD   = 1'b1;
    localparam logic       WR   = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa  [2];
    logic        rw   [2];
    logic [1:0]  sz   [2];
    logic [8:0]  ad   [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        moc  [2];
    logic        moc_d [2];
    logic [31:0] last [2];
    int          lat_of [2] = '{0, 2};

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic [1:0]  s;
        logic [8:0]  a;
        logic [31:0] d;
        int          hold;
    } vec_t;

    always #5 clk = ~clk;

    ram_responder #(.ADDR_WIDTH(9), .LATENCY(0)) u_lat0 (
        .Clk(clk), .Reset(rst), .MFA(mfa[0]), .RW(rw[0]), .Size(sz[0]),
        .Address(ad[0]), .DataIn(din[0]), .DataOut(dout[0]), .MOC(moc[0])
    );

    ram_responder #(.ADDR_WIDTH(9), .LATENCY(2)) u_lat2 (
        .Clk(clk), .Reset(rst), .MFA(mfa[1]), .RW(rw[1]), .Size(sz[1]),
        .Address(ad[1]), .DataIn(din[1]), .DataOut(dout[1]), .MOC(moc[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input logic [31:0] v);
        if (sel == 0) exp_q0.push_back(v);
        else          exp_q1.push_back(v);
    endtask

    // Monitor: on every MOC rise, DataOut must equal the next queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (moc[i] && !moc_d[i]) begin
                if (i == 0 && exp_q0.size() > 0) begin
                    check("dataout_lat0", dout[0], exp_q0.pop_front());
                end else if (i == 1 && exp_q1.size() > 0) begin
                    check("dataout_lat2", dout[1], exp_q1.pop_front());
                end else begin
                    check("unexpected_moc", {31'd0, moc[i]}, 32'd0);
                end
            end
            moc_d[i] <= moc[i];
        end
    end

    // Full handshake. extra=1 when the request is raised during the RELEASE cycle.
    task automatic req(input int sel, input logic r, input logic [1:0] s, input logic [8:0] a,
                       input logic [31:0] d, input int hold, input int extra, input bit b2b_next);
        int n;
        if (r) last[sel] = d;
        push(sel, last[sel]);
        @(negedge clk);
        mfa[sel] = 1'b1; rw[sel] = r; sz[sel] = s; ad[sel] = a; din[sel] = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1 + extra) begin
                // Scramble everything but MFA after capture; the DUT must ignore it.
                rw[sel] = ~r; sz[sel] = ~s; ad[sel] = ~a; din[sel] = ~d;
            end
        end while (!moc[sel] && n < 40);
        check("latency", 32'(n), 32'(lat_of[sel] + 2 + extra));
        repeat (hold) begin
            @(posedge clk); #1;
            check("moc_hold", {31'd0, moc[sel]}, 32'd1);
        end
        @(negedge clk);
        mfa[sel] = 1'b0;
        @(posedge clk); #1;
        check("moc_fall", {31'd0, moc[sel]}, 32'd0);
        if (!b2b_next) begin
            @(posedge clk); #1;
            check("release_low", {31'd0, moc[sel]}, 32'd0);
        end
    endtask

    vec_t vecs [] = '{
        '{WR, SZ_W, 9'h010, 32'hDEADBEEF, 0},
        '{RD, SZ_B, 9'h010, 32'h000000DE, 0},
        '{RD, SZ_B, 9'h011, 32'h000000AD, 0},
        '{RD, SZ_B, 9'h012, 32'h000000BE, 0},
        '{RD, SZ_B, 9'h013, 32'h000000EF, 0},
        '{RD, SZ_H, 9'h012, 32'h0000BEEF, 0},
        '{RD, SZ_B, 9'h011, 32'h000000AD, 0},
        '{RD, SZ_W, 9'h013, 32'hDEADBEEF, 0},
        '{WR, SZ_B, 9'h012, 32'hFFFFFF55, 0},
        '{RD, SZ_W, 9'h010, 32'hDEAD55EF, 0},
        '{WR, SZ_H, 9'h011, 32'hFFFFA5C3, 0},
        '{RD, SZ_W, 9'h010, 32'hA5C355EF, 0},
        '{RD, SZ_X, 9'h012, 32'hA5C355EF, 0},
        '{RD, SZ_B, 9'h013, 32'h000000EF, 5},
        '{WR, SZ_W, 9'h020, 32'hCAFEF00D, 0}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            mfa[i] = 1'b0; rw[i] = 1'b0; sz[i] = 2'b00; ad[i] = '0; din[i] = '0;
            last[i] = 32'd0;
        end
        // Reset with MFA held high on the LATENCY=2 instance: reset wins, no capture.
        rst = 1'b1;
        mfa[1] = 1'b1; rw[1] = WR; sz[1] = SZ_W; ad[1] = 9'h010; din[1] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_moc", {31'd0, moc[i]}, 32'd0);
            check("reset_dataout", dout[i], 32'd0);
        end
        rst = 1'b0;
        mfa[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("no_capture_in_reset", {31'd0, moc[1]}, 32'd0);

        // LATENCY=2 directed table.
        foreach (vecs[i]) begin
            req(1, vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].hold, 0, 1'b0);
        end

        // MFA dropped during WAIT: access completes, MOC pulses for one cycle.
        last[1] = 32'h000000A5;
        push(1, last[1]);
        @(negedge clk);
        mfa[1] = 1'b1; rw[1] = RD; sz[1] = SZ_B; ad[1] = 9'h010;
        @(posedge clk); #1;
        mfa[1] = 1'b0;
        n = 1;
        while (!moc[1] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drop_latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        check("drop_pulse_end", {31'd0, moc[1]}, 32'd0);
        @(posedge clk); #1;

        // Reset during WAIT aborts the write to 0x020.
        @(negedge clk);
        mfa[1] = 1'b1; rw[1] = WR; sz[1] = SZ_W; ad[1] = 9'h020; din[1] = 32'h12345678;
        @(posedge clk); #1;
        mfa[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort_moc", {31'd0, moc[1]}, 32'd0);
        check("abort_dataout", dout[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last[0] = 32'd0;
        last[1] = 32'd0;
        repeat (5) @(posedge clk);
        #1 check("abort_no_moc", {31'd0, moc[1]}, 32'd0);
        req(1, RD, SZ_W, 9'h020, 32'hCAFEF00D, 0, 0, 1'b0);
        req(1, RD, SZ_B, 9'h023, 32'h0000000D, 0, 0, 1'b0);

        // LATENCY=0 instance, back-to-back requests through the RELEASE cycle.
        req(0, WR, SZ_W, 9'h040, 32'hA1B2C3D4, 0, 0, 1'b1);
        req(0, RD, SZ_W, 9'h040, 32'hA1B2C3D4, 0, 1, 1'b1);
        req(0, RD, SZ_H, 9'h043, 32'h0000C3D4, 0, 1, 1'b1);
        req(0, RD, SZ_B, 9'h041, 32'h000000B2, 2, 1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue0_drained", 32'(exp_q0.size()), 32'd0);
        check("queue1_drained", 32'(exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
